// File: rtl/jtag_cmd_sequencer.sv
// rtl/jtag_cmd_sequencer.sv - command-level JTAG driver producing tck/tms/tdi/trst and capturing tdo
// Each command runs from Run-Test/Idle back to Run-Test/Idle; one response per command.
module jtag_cmd_sequencer #(
    parameter int MAX_LEN = 32,
    parameter int CLK_DIV = 4
) (
    input  logic                         sys_clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
    input  logic [MAX_LEN-1:0]           cmd_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [MAX_LEN-1:0]           rsp_data,
    output logic                         tck,
    output logic                         tms,
    output logic                         tdi,
    output logic                         trst,
    input  logic                         tdo
);
    localparam int KW = $clog2(MAX_LEN + 7);
    localparam int PW = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] POS_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;
    localparam logic [1:0] OP_IDLE  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_SHIFT, S_TRL, S_BITS, S_RSP} state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [1:0]         r_op;
    logic [KW-1:0]      r_n;
    logic [KW-1:0]      r_hdr;
    logic [KW-1:0]      r_total;
    logic [MAX_LEN-1:0] r_data;
    logic [KW-1:0]      r_k;
    logic [PW-1:0]      r_pos;
    logic               r_tck;
    logic               r_tms;
    logic               r_tdi;
    logic               r_trst;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic [MAX_LEN-1:0] r_rsp_data;

    logic [KW-1:0]      w_len_n;
    logic [KW-1:0]      w_hdr_in;
    logic [KW-1:0]      w_total_in;
    logic               w_accept;
    logic               w_busy;
    logic               w_wrap;
    logic [PW-1:0]      w_pos_nx;
    logic [KW-1:0]      w_k_nx;
    logic               w_last;
    logic [KW-1:0]      w_shift_end;
    logic               w_in_shift;
    logic [KW-1:0]      w_sidx;
    logic [MAX_LEN-1:0] w_sel;
    logic               w_tdi_nx;
    logic               w_tms_nx;

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign tck       = r_tck;
    assign tms       = r_tms;
    assign tdi       = r_tdi;
    assign trst      = r_trst;

    always_comb begin
        w_len_n = KW'(cmd_len);
        if (cmd_len == '0)
            w_len_n = KW'(1);
        else if (int'(cmd_len) > MAX_LEN)
            w_len_n = KW'(MAX_LEN);
        w_hdr_in   = '0;
        w_total_in = w_len_n;
        case (cmd_op)
            OP_RESET: w_total_in = KW'(6);
            OP_IR: begin
                w_hdr_in   = KW'(4);
                w_total_in = w_len_n + KW'(6);
            end
            OP_DR: begin
                w_hdr_in   = KW'(3);
                w_total_in = w_len_n + KW'(5);
            end
            default: w_total_in = w_len_n;
        endcase
    end

    // r_k/r_pos describe the current cycle; the accept cycle sits at the tail of a virtual bit -1
    assign w_accept    = (r_state == S_IDLE) && r_cmd_ready && cmd_valid;
    assign w_busy      = (r_state == S_HDR) || (r_state == S_SHIFT) ||
                         (r_state == S_TRL) || (r_state == S_BITS);
    assign w_wrap      = (r_pos == POS_LAST);
    assign w_pos_nx    = w_wrap ? '0 : r_pos + PW'(1);
    assign w_k_nx      = w_wrap ? r_k + KW'(1) : r_k;
    assign w_last      = w_wrap && (w_k_nx == r_total);
    assign w_shift_end = r_hdr + r_n;
    assign w_in_shift  = ((r_op == OP_IR) || (r_op == OP_DR)) &&
                         (w_k_nx >= r_hdr) && (w_k_nx < w_shift_end);
    assign w_sidx      = w_k_nx - r_hdr;
    assign w_sel       = MAX_LEN'(1) << w_sidx;
    assign w_tdi_nx    = w_in_shift && (|(r_data & w_sel));

    always_comb begin
        w_tms_nx = 1'b0;
        case (r_op)
            OP_RESET: w_tms_nx = (w_k_nx < KW'(5));
            OP_IR:    w_tms_nx = (w_k_nx < KW'(2)) || (w_k_nx == w_shift_end - KW'(1)) ||
                                 (w_k_nx == w_shift_end);
            OP_DR:    w_tms_nx = (w_k_nx == '0) || (w_k_nx == w_shift_end - KW'(1)) ||
                                 (w_k_nx == w_shift_end);
            default:  w_tms_nx = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_nx = ((cmd_op == OP_IR) || (cmd_op == OP_DR)) ? S_HDR : S_BITS;
            end
            S_HDR, S_SHIFT, S_TRL: begin
                if (w_last)
                    w_state_nx = S_RSP;
                else if (w_wrap) begin
                    if (w_k_nx < r_hdr)
                        w_state_nx = S_HDR;
                    else if (w_in_shift)
                        w_state_nx = S_SHIFT;
                    else
                        w_state_nx = S_TRL;
                end
            end
            S_BITS: if (w_last) w_state_nx = S_RSP;
            S_RSP:  if (rsp_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_op        <= OP_IDLE;
            r_n         <= '0;
            r_hdr       <= '0;
            r_total     <= '0;
            r_data      <= '0;
            r_k         <= '0;
            r_pos       <= '0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_trst      <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_trst      <= 1'b1;
            r_cmd_ready <= (w_state_nx == S_IDLE);
            if (r_state == S_IDLE) begin
                r_tck <= 1'b0;
                r_tms <= 1'b0;
                r_tdi <= 1'b0;
                if (w_accept) begin
                    r_op       <= cmd_op;
                    r_n        <= w_len_n;
                    r_hdr      <= w_hdr_in;
                    r_total    <= w_total_in;
                    r_data     <= cmd_data;
                    r_k        <= '1;
                    r_pos      <= POS_LAST;
                    r_rsp_data <= '0;
                end
            end else if (w_busy) begin
                r_pos <= w_pos_nx;
                r_k   <= w_k_nx;
                if (w_last) begin
                    r_tck       <= 1'b0;
                    r_tms       <= 1'b0;
                    r_tdi       <= 1'b0;
                    r_rsp_valid <= 1'b1;
                end else begin
                    r_tck <= (int'(w_pos_nx) >= CLK_DIV);
                    if (w_pos_nx == '0) begin
                        r_tms <= w_tms_nx;
                        r_tdi <= w_tdi_nx;
                    end
                    // tdo sampled on the edge that raises tck
                    if ((int'(w_pos_nx) == CLK_DIV) && w_in_shift)
                        r_rsp_data <= r_rsp_data | (tdo ? w_sel : '0);
                end
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtag_cmd_sequencer.sv
// tb/tb_jtag_cmd_sequencer.sv - directed bench for jtag_cmd_sequencer with a behavioural TAP model
module tb_jtag_cmd_sequencer;
    localparam int MAX_LEN = 32;
    localparam int CLK_DIV = 2;
    localparam logic [3:0]  IDCODE_OP = 4'b0010;
    localparam logic [3:0]  BYPASS_OP = 4'b1111;
    localparam logic [31:0] IDCODE    = 32'h4BA0_0477;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        trst;
    logic        tdo = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    jtag_cmd_sequencer #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
        .sys_clk(sys_clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .tck(tck), .tms(tms), .tdi(tdi), .trst(trst), .tdo(tdo)
    );

    always #5 sys_clk = ~sys_clk;

    typedef enum logic [3:0] {TLR, RTI, SDS, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                              SIS, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
    tap_t        tap_st;
    logic [3:0]  ir;
    logic [3:0]  ir_sr = 4'b0;
    logic [31:0] dr_sr = 32'b0;
    logic        byp   = 1'b0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:  return m ? TLR  : RTI;
            RTI:  return m ? SDS  : RTI;
            SDS:  return m ? SIS  : CDR;
            CDR:  return m ? E1DR : SHDR;
            SHDR: return m ? E1DR : SHDR;
            E1DR: return m ? UDR  : PDR;
            PDR:  return m ? E2DR : PDR;
            E2DR: return m ? UDR  : SHDR;
            UDR:  return m ? SDS  : RTI;
            SIS:  return m ? TLR  : CIR;
            CIR:  return m ? E1IR : SHIR;
            SHIR: return m ? E1IR : SHIR;
            E1IR: return m ? UIR  : PIR;
            PIR:  return m ? E2IR : PIR;
            E2IR: return m ? UIR  : SHIR;
            default: return m ? SDS : RTI;
        endcase
    endfunction

    always @(posedge tck or negedge trst) begin
        if (!trst) begin
            tap_st <= TLR;
            ir     <= IDCODE_OP;
        end else begin
            case (tap_st)
                TLR:  ir <= IDCODE_OP;
                CDR:  if (ir == IDCODE_OP) dr_sr <= IDCODE; else byp <= 1'b0;
                SHDR: if (ir == IDCODE_OP) dr_sr <= {tdi, dr_sr[31:1]}; else byp <= tdi;
                CIR:  ir_sr <= 4'b0001;
                SHIR: ir_sr <= {tdi, ir_sr[3:1]};
                UIR:  ir <= ir_sr;
                default: ;
            endcase
            tap_st <= tap_next(tap_st, tms);
        end
    end

    always @(negedge tck) begin
        if (tap_st == SHDR)      tdo <= (ir == IDCODE_OP) ? dr_sr[0] : byp;
        else if (tap_st == SHIR) tdo <= ir_sr[0];
        else                     tdo <= 1'b0;
    end

    // Issues one command and follows it until rsp_valid; cyc is the cycle index after the accept edge
    task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                           output int cyc, output int nbits, output logic [63:0] tmsv,
                           output logic [31:0] rsp);
        logic prev;
        @(negedge sys_clk);
        cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        cmd_valid = 1'b0; cmd_op = ~op; cmd_len = 6'd17; cmd_data = ~data;
        cyc = -1; nbits = 0; tmsv = '0; rsp = 'x; prev = tck;
        for (int c = 1; c < 2000; c++) begin
            @(negedge sys_clk);
            if (!prev && tck) begin
                if (nbits < 64) tmsv[nbits] = tms;
                nbits++;
            end
            prev = tck;
            if (rsp_valid) begin
                cyc = c;
                rsp = rsp_data;
                break;
            end
        end
    endtask

    task automatic take_rsp();
        @(negedge sys_clk);
        rsp_ready = 1'b1;
        @(negedge sys_clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = '0; cmd_data = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_tests += 7;
        if (tck !== 1'b0)       begin n_fail++; $display("FAIL reset_tck got %b exp 0", tck); end
        if (tms !== 1'b1)       begin n_fail++; $display("FAIL reset_tms got %b exp 1", tms); end
        if (tdi !== 1'b0)       begin n_fail++; $display("FAIL reset_tdi got %b exp 0", tdi); end
        if (trst !== 1'b0)      begin n_fail++; $display("FAIL reset_trst got %b exp 0", trst); end
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
        reset = 1'b0;
        @(negedge sys_clk);
        n_tests += 3;
        if (trst !== 1'b1)      begin n_fail++; $display("FAIL release_trst got %b exp 1", trst); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL release_cmd_ready got %b exp 1", cmd_ready); end
        if (tms !== 1'b0)       begin n_fail++; $display("FAIL release_tms got %b exp 0", tms); end
    endtask

    task automatic test_tap_reset();
        int cyc, nb; logic [63:0] tv; logic [31:0] r;
        run_cmd(2'b00, 6'd3, 32'hFFFF_FFFF, cyc, nb, tv, r);
        n_tests += 5;
        if (cyc !== 25)      begin n_fail++; $display("FAIL tapreset_cycle got %0d exp 25", cyc); end
        if (nb !== 6)        begin n_fail++; $display("FAIL tapreset_nbits got %0d exp 6", nb); end
        if (tv !== 64'h1F)   begin n_fail++; $display("FAIL tapreset_tms got %h exp 1f", tv); end
        if (r !== 32'h0)     begin n_fail++; $display("FAIL tapreset_rsp got %h exp 0", r); end
        if (tck !== 1'b0)    begin n_fail++; $display("FAIL tapreset_tck_idle got %b exp 0", tck); end
        take_rsp();
    endtask

    task automatic test_idcode();
        int cyc, nb; logic [63:0] tv; logic [31:0] r;
        run_cmd(2'b01, 6'd4, {28'h0, IDCODE_OP}, cyc, nb, tv, r);
        n_tests += 4;
        if (cyc !== 41)      begin n_fail++; $display("FAIL ir_cycle got %0d exp 41", cyc); end
        if (nb !== 10)       begin n_fail++; $display("FAIL ir_nbits got %0d exp 10", nb); end
        if (tv !== 64'h183)  begin n_fail++; $display("FAIL ir_tms got %h exp 183", tv); end
        if (r !== 32'h1)     begin n_fail++; $display("FAIL ir_capture got %h exp 1", r); end
        take_rsp();
        run_cmd(2'b10, 6'd32, 32'h0, cyc, nb, tv, r);
        n_tests += 3;
        if (r !== IDCODE)    begin n_fail++; $display("FAIL idcode got %h exp %h", r, IDCODE); end
        if (nb !== 37)       begin n_fail++; $display("FAIL idcode_nbits got %0d exp 37", nb); end
        if (cyc !== 149)     begin n_fail++; $display("FAIL idcode_cycle got %0d exp 149", cyc); end
        take_rsp();
    endtask

    task automatic test_bypass();
        int cyc, nb; logic [63:0] tv; logic [31:0] r;
        run_cmd(2'b01, 6'd4, {28'h0, BYPASS_OP}, cyc, nb, tv, r);
        take_rsp();
        run_cmd(2'b10, 6'd8, 32'hA5, cyc, nb, tv, r);
        n_tests += 2;
        if (r !== 32'h4A)    begin n_fail++; $display("FAIL bypass_a5 got %h exp 4a", r); end
        if (nb !== 13)       begin n_fail++; $display("FAIL bypass_nbits got %0d exp 13", nb); end
        take_rsp();
    endtask

    task automatic test_len_edges();
        int cyc, nb; logic [63:0] tv; logic [31:0] r;
        run_cmd(2'b10, 6'd0, 32'h1, cyc, nb, tv, r);
        n_tests += 3;
        if (nb !== 6)        begin n_fail++; $display("FAIL len0_nbits got %0d exp 6", nb); end
        if (tv !== 64'h19)   begin n_fail++; $display("FAIL len0_tms got %h exp 19", tv); end
        if (r !== 32'h0)     begin n_fail++; $display("FAIL len0_rsp got %h exp 0", r); end
        take_rsp();
        run_cmd(2'b10, 6'(MAX_LEN + 5), 32'hFFFF_FFFF, cyc, nb, tv, r);
        n_tests += 3;
        if (nb !== 37)       begin n_fail++; $display("FAIL lenmax_nbits got %0d exp 37", nb); end
        if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL lenmax_rsp got %h exp fffffffe", r); end
        if (cyc !== 149)     begin n_fail++; $display("FAIL lenmax_cycle got %0d exp 149", cyc); end
        take_rsp();
    endtask

    task automatic test_backpressure();
        int cyc, nb, bad; logic [63:0] tv; logic [31:0] r;
        run_cmd(2'b10, 6'd8, 32'h3C, cyc, nb, tv, r);
        n_tests += 2;
        if (cyc !== 53)      begin n_fail++; $display("FAIL bp_cycle got %0d exp 53", cyc); end
        if (r !== 32'h78)    begin n_fail++; $display("FAIL bp_rsp got %h exp 78", r); end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge sys_clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h78 || cmd_ready !== 1'b0 || tck !== 1'b0)
                bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL bp_hold got %0d unstable cycles exp 0", bad); end
        rsp_ready = 1'b1;
        @(negedge sys_clk);
        rsp_ready = 1'b0;
        n_tests += 2;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", cmd_ready); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b exp 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int cyc, nb; logic [63:0] tv; logic [31:0] r;
        rsp_ready = 1'b1;
        run_cmd(2'b11, 6'd2, 32'hFFFF_FFFF, cyc, nb, tv, r);
        n_tests += 3;
        if (cyc !== 9)       begin n_fail++; $display("FAIL idle_cycle got %0d exp 9", cyc); end
        if (nb !== 2)        begin n_fail++; $display("FAIL idle_nbits got %0d exp 2", nb); end
        if (tv !== 64'h0)    begin n_fail++; $display("FAIL idle_tms got %h exp 0", tv); end
        @(negedge sys_clk);
        n_tests += 2;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL early_ready_cmd_ready got %b exp 1", cmd_ready); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL early_ready_rsp_valid got %b exp 0", rsp_valid); end
        run_cmd(2'b00, 6'd0, 32'h1234_5678, cyc, nb, tv, r);
        n_tests += 3;
        if (cyc !== 25)      begin n_fail++; $display("FAIL b2b_reset_cycle got %0d exp 25", cyc); end
        if (tv !== 64'h1F)   begin n_fail++; $display("FAIL b2b_reset_tms got %h exp 1f", tv); end
        if (r !== 32'h0)     begin n_fail++; $display("FAIL b2b_reset_rsp got %h exp 0", r); end
        @(negedge sys_clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge sys_clk);
        cmd_op = 2'b10; cmd_len = 6'd8; cmd_data = 32'hFF; cmd_valid = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        repeat (26) @(negedge sys_clk);
        n_tests++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b exp 0", cmd_ready); end
        reset = 1'b1;
        #1;
        n_tests += 6;
        if (tck !== 1'b0)       begin n_fail++; $display("FAIL mid_tck got %b exp 0", tck); end
        if (tms !== 1'b1)       begin n_fail++; $display("FAIL mid_tms got %b exp 1", tms); end
        if (tdi !== 1'b0)       begin n_fail++; $display("FAIL mid_tdi got %b exp 0", tdi); end
        if (trst !== 1'b0)      begin n_fail++; $display("FAIL mid_trst got %b exp 0", trst); end
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_cmd_ready got %b exp 0", cmd_ready); end
        if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL mid_rsp_data got %h exp 0", rsp_data); end
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge sys_clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        n_tests += 3;
        if (seen !== 0)         begin n_fail++; $display("FAIL mid_no_rsp got %0d exp 0", seen); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after_ready got %b exp 1", cmd_ready); end
        if (tck !== 1'b0)       begin n_fail++; $display("FAIL mid_after_tck got %b exp 0", tck); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tap_reset();
        test_idcode();
        test_bypass();
        test_len_edges();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
